// File: rtl/seven_segment_capture_if.sv
// Bundles the multiplexed display bus and the captured-frame VALID/READY stream.
// master = capture block (consumes the display, sources frames); slave = environment.
interface seven_segment_capture_if;
  logic [3:0]  an;
  logic        ca;
  logic        cb;
  logic        cc;
  logic        cd;
  logic        ce;
  logic        cf;
  logic        cg;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic [3:0]  dig_ok;
  logic        ovr;

  modport master (
    input  an, ca, cb, cc, cd, ce, cf, cg, ready,
    output data, valid, dig_ok, ovr
  );

  modport slave (
    output an, ca, cb, cc, cd, ce, cf, cg, ready,
    input  data, valid, dig_ok, ovr
  );
endinterface

// File: rtl/seven_segment_capture.sv
// Recovers the 16-bit hex word shown on a multiplexed 4-digit common-anode display.
// Define SEVEN_SEG_GLYPH_CHECK_EN to track per-digit glyph legality on DIG_OK.
module seven_segment_capture #(
  parameter int unsigned StableCycles = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  seven_segment_capture_if.master bus
);

  localparam logic [7:0] StableCnt = 8'(StableCycles);

  // Lit patterns {g,f,e,d,c,b,a} indexed by nibble value.
  localparam logic [6:0] Glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic [3:0]  an_s1_q, an_s2_q;
  logic [6:0]  seg_s1_q, seg_s2_q;
  logic [10:0] pat_q, pat_d;
  logic [7:0]  run_q, run_d;
  logic        taken_q, taken_d;
  logic [15:0] slot_nib_q, slot_nib_d;
  logic [3:0]  filled_q, filled_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;

  logic        change;
  logic [3:0]  an_low;
  logic        one_low;
  logic        capture;
  logic [6:0]  lit;
  logic [3:0]  dec_nib;
  logic        complete;
  logic        load;

`ifdef SEVEN_SEG_GLYPH_CHECK_EN
  logic [3:0]  slot_ok_q, slot_ok_d;
  logic [3:0]  dig_ok_q, dig_ok_d;
  logic        dec_legal;
`endif

  always_comb begin
    pat_d   = {an_s2_q, seg_s2_q};
    change  = (pat_d != pat_q);
    an_low  = ~pat_q[10:7];
    one_low = (an_low != 4'h0) && ((an_low & (an_low - 4'd1)) == 4'h0);
    // The dwell being judged is the one recorded in pat_q; a change arriving on the
    // same edge only starts the next dwell.
    capture = (run_q == StableCnt) && one_low && !taken_q;
    lit     = ~pat_q[6:0];

    dec_nib = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (lit == Glyph[i]) dec_nib = 4'(i);
    end
`ifdef SEVEN_SEG_GLYPH_CHECK_EN
    dec_legal = (dec_nib != 4'h0) || (lit == Glyph[0]);
`endif

    if (change) begin
      run_d   = 8'd1;
      taken_d = 1'b0;
    end else begin
      run_d   = (run_q != 8'hFF) ? run_q + 8'd1 : run_q;
      taken_d = taken_q | capture;
    end

    complete   = (filled_q == 4'hF);
    slot_nib_d = slot_nib_q;
    filled_d   = complete ? 4'h0 : filled_q;
`ifdef SEVEN_SEG_GLYPH_CHECK_EN
    slot_ok_d  = slot_ok_q;
`endif
    for (int i = 0; i < 4; i++) begin
      if (capture && an_low[i]) begin
        slot_nib_d[4*i +: 4] = dec_nib;
        filled_d[i]          = 1'b1;
`ifdef SEVEN_SEG_GLYPH_CHECK_EN
        slot_ok_d[i]         = dec_legal;
`endif
      end
    end

    // A finished frame is only accepted if the output register is free this edge.
    load    = complete && (!valid_q || bus.ready);
    data_d  = load ? slot_nib_q : data_q;
    valid_d = load ? 1'b1 : (valid_q && !bus.ready);
    ovr_d   = ovr_q | (complete && !load);
`ifdef SEVEN_SEG_GLYPH_CHECK_EN
    dig_ok_d = load ? slot_ok_q : dig_ok_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1_q    <= 4'hF;
      an_s2_q    <= 4'hF;
      seg_s1_q   <= 7'h7F;
      seg_s2_q   <= 7'h7F;
      pat_q      <= 11'h7FF;
      run_q      <= 8'd0;
      taken_q    <= 1'b0;
      slot_nib_q <= 16'h0;
      filled_q   <= 4'h0;
      data_q     <= 16'h0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      an_s1_q    <= bus.an;
      an_s2_q    <= an_s1_q;
      seg_s1_q   <= {bus.cg, bus.cf, bus.ce, bus.cd, bus.cc, bus.cb, bus.ca};
      seg_s2_q   <= seg_s1_q;
      pat_q      <= pat_d;
      run_q      <= run_d;
      taken_q    <= taken_d;
      slot_nib_q <= slot_nib_d;
      filled_q   <= filled_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

`ifdef SEVEN_SEG_GLYPH_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_ok_q <= 4'h0;
      dig_ok_q  <= 4'h0;
    end else begin
      slot_ok_q <= slot_ok_d;
      dig_ok_q  <= dig_ok_d;
    end
  end

  assign bus.dig_ok = dig_ok_q;
`else
  assign bus.dig_ok = 4'hF;
`endif

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.ovr   = ovr_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Self-checking bench for seven_segment_capture: vector table, hand-written corner
// sequences and randomized frames scored against a glyph-table reference model.
module tb_seven_segment_capture;

  localparam int unsigned Stable = 4;

`ifdef SEVEN_SEG_GLYPH_CHECK_EN
  localparam logic [3:0] ResetOk = 4'h0;
`else
  localparam logic [3:0] ResetOk = 4'hF;
`endif

  logic clk = 1'b0;
  logic rst_n;

  seven_segment_capture_if bus ();

  seven_segment_capture #(
    .StableCycles(Stable)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int total = 0;
  int bad   = 0;

  logic [15:0] got_data [$];
  logic [3:0]  got_ok   [$];
  logic [15:0] exp_data [$];
  logic [3:0]  exp_ok   [$];
  int          valid_cycles = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid) valid_cycles++;
      if (bus.valid && bus.ready) begin
        got_data.push_back(bus.data);
        got_ok.push_back(bus.dig_ok);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic bit is_glyph(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (glyph_tab[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  task automatic show(input logic [3:0] an, input logic [6:0] lit, input int n);
    bus.an = an;
    {bus.cg, bus.cf, bus.ce, bus.cd, bus.cc, bus.cb, bus.ca} = ~lit;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [27:0] lits, input int dwell);
    for (int d = 0; d < 4; d++) show(~(4'b0001 << d), lits[7*d +: 7], dwell);
  endtask

  task automatic compare_frames(input string name, input bit chk_valid);
    int n;
    bus.an = 4'hF;
    repeat (12) @(posedge clk);
    #1;
    check({name, "_frames"}, got_data.size(), exp_data.size());
    if (chk_valid) check({name, "_valid_cycles"}, valid_cycles, exp_data.size());
    n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", name, i), got_data[i], exp_data[i]);
      check($sformatf("%s_digok%0d", name, i), got_ok[i], exp_ok[i]);
    end
    got_data.delete();
    got_ok.delete();
    exp_data.delete();
    exp_ok.delete();
    valid_cycles = 0;
  endtask

  typedef struct {
    string       name;
    logic [27:0] lits;    // digit i lit pattern at [7i+6:7i]
    int          dwell;
    int          frames;
    logic [15:0] data;
    logic [3:0]  ok;
  } vec_t;

  vec_t vecs [6];

  initial begin
`ifdef SEVEN_SEG_GLYPH_CHECK_EN
    logic [3:0] ok_illegal2 = 4'b1011;
`else
    logic [3:0] ok_illegal2 = 4'hF;
`endif
    vecs[0] = '{"v6543",   {7'h7D, 7'h6D, 7'h66, 7'h4F}, 8, 1, 16'h6543, 4'hF};
    vecs[1] = '{"short3",  {7'h66, 7'h4F, 7'h5B, 7'h06}, 3, 0, 16'h0000, 4'hF};
    vecs[2] = '{"long6",   {7'h66, 7'h4F, 7'h5B, 7'h06}, 6, 1, 16'h4321, 4'hF};
    vecs[3] = '{"illegal", {7'h7F, 7'h01, 7'h06, 7'h3F}, 5, 1, 16'h8010, ok_illegal2};
    vecs[4] = '{"edge4",   {7'h5E, 7'h39, 7'h7C, 7'h77}, 4, 1, 16'hDCBA, 4'hF};
    vecs[5] = '{"v76fe",   {7'h07, 7'h7D, 7'h71, 7'h79}, 9, 1, 16'h76FE, 4'hF};

    rst_n     = 1'b0;
    bus.ready = 1'b1;
    bus.an    = 4'hF;
    {bus.cg, bus.cf, bus.ce, bus.cd, bus.cc, bus.cb, bus.ca} = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", bus.data, 16'h0);
    check("rst_valid", bus.valid, 1'b0);
    check("rst_digok", bus.dig_ok, ResetOk);
    check("rst_ovr", bus.ovr, 1'b0);
    rst_n = 1'b1;
    show(4'hF, 7'h00, 3);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].lits, vecs[v].dwell);
      if (vecs[v].frames != 0) begin
        exp_data.push_back(vecs[v].data);
        exp_ok.push_back(vecs[v].ok);
      end
      compare_frames(vecs[v].name, 1'b1);
    end

    // Two low anodes must never write a slot, so the partial frame survives
    show(4'b1110, 7'h6D, 6);
    show(4'b1101, 7'h6F, 6);
    show(4'b1100, 7'h7F, 20);
    show(4'hF, 7'h00, 3);
    show(4'b1011, 7'h07, 6);
    show(4'b0111, 7'h5B, 6);
    exp_data.push_back(16'h2795);
    exp_ok.push_back(4'hF);
    compare_frames("multi_an", 1'b1);

    // Randomized frames with short glitch dwells that must be ignored
    for (int f = 0; f < 25; f++) begin
      logic [27:0] lits;
      logic [15:0] ew;
      logic [3:0]  eo;
      for (int d = 0; d < 4; d++) begin
        logic [6:0] p;
        logic [3:0] n;
        if ($urandom_range(0, 5) == 0) begin
          do p = 7'($urandom_range(0, 127)); while (is_glyph(p));
          ew[4*d +: 4] = 4'h0;
          eo[d]        = 1'b0;
        end else begin
          n            = 4'($urandom_range(0, 15));
          p            = glyph_tab[n];
          ew[4*d +: 4] = n;
          eo[d]        = 1'b1;
        end
        lits[7*d +: 7] = p;
      end
`ifndef SEVEN_SEG_GLYPH_CHECK_EN
      eo = 4'hF;
`endif
      for (int d = 0; d < 4; d++) begin
        if ($urandom_range(0, 3) == 0)
          show(~(4'b0001 << $urandom_range(0, 3)), 7'($urandom_range(0, 127)),
               $urandom_range(1, Stable - 1));
        show(~(4'b0001 << d), lits[7*d +: 7], $urandom_range(Stable, Stable + 5));
      end
      exp_data.push_back(ew);
      exp_ok.push_back(eo);
    end
    compare_frames("random", 1'b1);

    // Overrun: second frame dropped while the first is held
    bus.ready = 1'b0;
    send_frame({7'h06, 7'h5B, 7'h4F, 7'h66}, 6);
    show(4'hF, 7'h00, 6);
    check("ovr_first_valid", bus.valid, 1'b1);
    check("ovr_first_data", bus.data, 16'h1234);
    check("ovr_before", bus.ovr, 1'b0);
    send_frame({7'h77, 7'h7C, 7'h39, 7'h5E}, 6);
    show(4'hF, 7'h00, 6);
    check("ovr_hold_data", bus.data, 16'h1234);
    check("ovr_hold_valid", bus.valid, 1'b1);
    check("ovr_set", bus.ovr, 1'b1);
    bus.ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_valid_drop", bus.valid, 1'b0);
    check("ovr_sticky", bus.ovr, 1'b1);
    exp_data.push_back(16'h1234);
    exp_ok.push_back(4'hF);
    compare_frames("ovr", 1'b0);

    // Reset mid-frame discards partial slots and clears the sticky overrun
    show(4'b1110, 7'h7F, 6);
    show(4'b1101, 7'h7F, 6);
    rst_n = 1'b0;
    #2;
    check("mid_rst_ovr", bus.ovr, 1'b0);
    check("mid_rst_valid", bus.valid, 1'b0);
    check("mid_rst_data", bus.data, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    show(4'b1011, 7'h79, 6);
    show(4'b0111, 7'h7C, 6);
    show(4'b1110, 7'h71, 6);
    show(4'b1101, 7'h79, 6);
    exp_data.push_back(16'hBEEF);
    exp_ok.push_back(4'hF);
    compare_frames("after_rst", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_capture.md
# seven_segment_capture

Receive-side companion to the hex-to-segment driver: monitors a multiplexed 4-digit common-anode seven-segment bus (active-low anodes, active-low cathodes CA..CG) and recovers the displayed 16-bit hex word. Used on the verification/readback side of the display path, so firmware and self-test logic can confirm what the panel shows. Debounces each digit dwell, decodes the glyph back to a nibble, assembles complete frames and hands them out over a VALID/READY handshake.

## Interface
- STABLE_CYCLES, 4, synchronized cycles a digit's {anode, segment} pattern must hold before capture; legal range 1..255.
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- AN  in  4  anode strobes, active-low; AN[0] = least significant digit.
- CA..CG  in  1 each  segment cathodes a..g, active-low (0 = segment lit).
- DATA  out  16  captured word; DATA[4i+3:4i] = digit i.
- VALID  out  1  DATA holds an untransferred frame.
- READY  in  1  consumer accepts DATA.
- DIG_OK  out  4  per digit: 1 = legal glyph decoded in the current DATA.
- OVR  out  1  sticky: a completed frame was dropped.

## Operation
- All of AN, CA..CG pass a 2-flop synchronizer; sync flops reset to 1 (inactive).
- Run counter (8 bit, saturating) counts consecutive cycles the synchronized 11-bit {AN, CG..CA} is unchanged; any change reloads to 1.
- Capture when run count reaches STABLE_CYCLES and exactly one AN bit is 0; only one capture per dwell (taken flag cleared on next change). AN with zero or multiple low bits: no capture.
- Decode lit pattern (bit6..0 = g,f,e,d,c,b,a, lit=1): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F. Any other pattern is illegal.
- Capture writes the slot for the low anode (nibble + legal flag) and sets that slot's filled bit; recapture of an already-filled slot overwrites it.
- Frame complete when all 4 filled bits set: slots copied to DATA/DIG_OK, filled bits cleared, VALID set.
- Handshake: transfer when VALID && READY at a rising edge; VALID clears next cycle unless a new frame completes that same cycle (then DATA reloads, VALID stays 1).
- Frame completing while VALID && !READY: frame discarded, filled bits still cleared, OVR set; OVR cleared only by reset.

## Timing
- Reset values: DATA=0, VALID=0, DIG_OK=0, OVR=0, run count=0, filled bits=0, taken=0.
- Reset mid-frame discards partial slots; mid-handshake drops VALID immediately (async).
- Input change at edge t → slot write at edge t+2+STABLE_CYCLES.
- Fourth slot write at edge n → VALID=1, DATA updated at edge n+1.
- DATA and DIG_OK stable while VALID=1 and no transfer has occurred.
- READY has no combinational path to any output.

## Configuration
- SEVEN_SEG_GLYPH_CHECK_EN defined: illegal patterns decode to nibble 0 with slot legal flag 0; DIG_OK reports per-digit legality.
- Not defined: no legality tracking; illegal patterns decode to 0, DIG_OK tied to 4'hF, legality storage removed.

## Test plan
- Drive digits 0..3 with lit patterns 4F,66,6D,7D (i.e. "6543"), each 8 cycles, STABLE_CYCLES=4, READY=1 → DATA=16'h6543, VALID one cycle, DIG_OK=4'hF.
- Dwell of 3 cycles per digit with STABLE_CYCLES=4 → no capture, VALID never rises; extend to 6 cycles → capture.
- Digit 2 shows lit pattern 0x01 (macro defined) → DATA[11:8]=0, DIG_OK=4'b1011; macro undefined → DIG_OK=4'hF.
- READY=0, two complete frames 16'h1234 then 16'hABCD → DATA stays 16'h1234, VALID held, OVR=1; READY=1 → transfer, VALID drops, OVR remains 1.
- AN=4'b1100 held 20 cycles, then AN=4'hF → no slot writes, filled bits unchanged.
- Assert RST_N low after two digits captured, release, send full frame 16'hBEEF → single VALID with 16'hBEEF, no stale nibbles.
